led_display_ram_arbiter: RTL and testbench

LED_DISPLAY_RAM_ARBITER -- requirements
Module: led_display_ram_arbiter

---
 rtl/led_display_pkg.sv | 7 +
 rtl/led_display_ram_arbiter.sv | 95 +++++++++
 tb/tb_led_display_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_display_pkg.sv
// led_display_pkg: shared panel defaults and swap FSM state type
package led_display_pkg;
    localparam int NUM_ROW_PIXELS_DEF = 32;
    localparam int NUM_COL_PIXELS_DEF = 64;
    localparam int PIXEL_BITS_DEF     = 24;
    typedef enum logic {SW_IDLE, SW_PENDING} swap_state_t;
endpackage

// File: rtl/led_display_ram_arbiter.sv
// led_display_ram_arbiter: reader-priority single-port RAM arbiter with double-buffered bank swap
module led_display_ram_arbiter
    import led_display_pkg::*;
#(
    parameter int NUM_ROW_PIXELS = NUM_ROW_PIXELS_DEF,
    parameter int NUM_COL_PIXELS = NUM_COL_PIXELS_DEF,
    parameter int PIXEL_BITS     = PIXEL_BITS_DEF,
    parameter int STARVE_LIMIT   = 8,
    localparam int ADDR_W   = $clog2(NUM_ROW_PIXELS * NUM_COL_PIXELS),
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk_in,
    input  logic                  n_reset_in,
    input  logic                  rd_valid_in,
    input  logic [ADDR_W-1:0]     rd_addr_in,
    input  logic                  rd_frame_end_in,
    output logic                  rd_ready_out,
    output logic [PIXEL_BITS-1:0] rd_data_out,
    output logic                  rd_data_valid_out,
    input  logic                  wr_valid_in,
    input  logic [ADDR_W-1:0]     wr_addr_in,
    input  logic [PIXEL_BITS-1:0] wr_data_in,
    output logic                  wr_ready_out,
    input  logic                  swap_req_in,
    output logic                  swap_done_out,
    output logic                  front_bank_out,
    output logic                  ram_en_out,
    output logic                  ram_we_out,
    output logic [ADDR_W:0]       ram_addr_out,
    output logic [PIXEL_BITS-1:0] ram_wdata_out,
    input  logic [PIXEL_BITS-1:0] ram_rdata_in
);
    swap_state_t state_q, state_d;
    logic front_bank_q, swap_done_q, toggle;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic rd_pipe_q, rd_data_valid_q;
    logic [PIXEL_BITS-1:0] rd_data_q;
    logic wr_grant, rd_grant, starved;

    // Grants are gated by reset so the RAM sees no command while held in reset
    assign starved  = starve_q == STARVE_W'(STARVE_LIMIT);
    assign wr_grant = n_reset_in && wr_valid_in && state_q == SW_IDLE && (!rd_valid_in || starved);
    assign rd_grant = n_reset_in && rd_valid_in && !wr_grant;

    assign rd_ready_out      = rd_grant;
    assign wr_ready_out      = wr_grant;
    assign ram_en_out        = rd_grant || wr_grant;
    assign ram_we_out        = wr_grant;
    assign ram_addr_out      = wr_grant ? {~front_bank_q, wr_addr_in} :
                               rd_grant ? {front_bank_q, rd_addr_in} : '0;
    assign ram_wdata_out     = wr_grant ? wr_data_in : '0;
    assign rd_data_out       = rd_data_q;
    assign rd_data_valid_out = rd_data_valid_q;
    assign swap_done_out     = swap_done_q;
    assign front_bank_out    = front_bank_q;

    assign starve_d = (!wr_valid_in || wr_grant) ? '0 :
                      (state_q == SW_IDLE && !starved) ? starve_q + 1'b1 : starve_q;

    always_comb begin
        state_d = state_q;
        toggle  = 1'b0;
        case (state_q)
            SW_IDLE: begin
                toggle  = swap_req_in && rd_frame_end_in;
                state_d = (swap_req_in && !rd_frame_end_in) ? SW_PENDING : SW_IDLE;
            end
            default: begin
                toggle  = rd_frame_end_in;
                state_d = rd_frame_end_in ? SW_IDLE : SW_PENDING;
            end
        endcase
    end

    // Read data carries no bank tag: the bank was fixed into the address at grant time
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q         <= SW_IDLE;
            front_bank_q    <= 1'b0;
            swap_done_q     <= 1'b0;
            starve_q        <= '0;
            rd_pipe_q       <= 1'b0;
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
        end else begin
            state_q         <= state_d;
            front_bank_q    <= front_bank_q ^ toggle;
            swap_done_q     <= toggle;
            starve_q        <= starve_d;
            rd_pipe_q       <= rd_grant;
            rd_data_valid_q <= rd_pipe_q;
            if (rd_pipe_q) rd_data_q <= ram_rdata_in;
        end
    end
endmodule

// File: tb/tb_led_display_ram_arbiter.sv
// tb_led_display_ram_arbiter: directed and randomized checks against a cycle-level arbitration model
module tb_led_display_ram_arbiter;
    localparam int AW = 11;
    localparam int PB = 24;
    localparam int LIM = 8;

    logic clk_in = 1'b0;
    logic n_reset_in = 1'b0;
    logic rd_valid_in = 1'b0, rd_frame_end_in = 1'b0, wr_valid_in = 1'b0, swap_req_in = 1'b0;
    logic [AW-1:0] rd_addr_in = '0, wr_addr_in = '0;
    logic [PB-1:0] wr_data_in = '0, ram_rdata_in;
    logic rd_ready_out, rd_data_valid_out, wr_ready_out, swap_done_out, front_bank_out;
    logic ram_en_out, ram_we_out;
    logic [PB-1:0] rd_data_out, ram_wdata_out;
    logic [AW:0] ram_addr_out;

    always #5 clk_in = ~clk_in;

    led_display_ram_arbiter dut (
        .clk_in(clk_in), .n_reset_in(n_reset_in),
        .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_frame_end_in(rd_frame_end_in),
        .rd_ready_out(rd_ready_out), .rd_data_out(rd_data_out), .rd_data_valid_out(rd_data_valid_out),
        .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_ready_out(wr_ready_out), .swap_req_in(swap_req_in), .swap_done_out(swap_done_out),
        .front_bank_out(front_bank_out), .ram_en_out(ram_en_out), .ram_we_out(ram_we_out),
        .ram_addr_out(ram_addr_out), .ram_wdata_out(ram_wdata_out), .ram_rdata_in(ram_rdata_in)
    );

    // Single-port RAM attached to the arbiter
    logic [PB-1:0] mem [0:(1<<(AW+1))-1];
    always @(posedge clk_in)
        if (ram_en_out) begin
            if (ram_we_out) mem[ram_addr_out] <= ram_wdata_out;
            else ram_rdata_in <= mem[ram_addr_out];
        end

    // Reference model: bank contents, expected returns keyed by due cycle
    typedef struct {int due; logic [PB-1:0] d;} ret_t;
    ret_t q[$];
    logic [PB-1:0] m_mem [0:(1<<(AW+1))-1];
    logic m_bank, m_pend, m_done;
    int m_starve, cyc;
    logic e_wrg, e_rdg, e_dv;
    logic [PB-1:0] e_data;
    logic [AW:0] e_addr;
    logic c_rv, c_wv, c_sr, c_fe;
    logic [AW-1:0] c_ra, c_wa;
    logic [PB-1:0] c_wd;
    int checks = 0, failures = 0;
    logic [PB-1:0] pat [4] = '{24'hA1B2C3, 24'h0F0F0F, 24'h123456, 24'hFEDCBA};

    task automatic model_clear();
        m_bank = 0; m_pend = 0; m_done = 0; m_starve = 0;
        q.delete();
    endtask

    task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic wv,
                         input logic [AW-1:0] wa, input logic [PB-1:0] wd,
                         input logic sr, input logic fe);
        c_rv = rv; c_ra = ra; c_wv = wv; c_wa = wa; c_wd = wd; c_sr = sr; c_fe = fe;
        rd_valid_in = rv; rd_addr_in = ra; wr_valid_in = wv; wr_addr_in = wa;
        wr_data_in = wd; swap_req_in = sr; rd_frame_end_in = fe;
        #1;
        e_wrg  = wv && !m_pend && (!rv || m_starve == LIM);
        e_rdg  = rv && !e_wrg;
        e_addr = e_wrg ? {~m_bank, wa} : e_rdg ? {m_bank, ra} : '0;
        e_dv   = q.size() > 0 && q[0].due == cyc;
        e_data = e_dv ? q[0].d : '0;
    endtask

    task automatic advance();
        logic tog;
        if (e_wrg) m_mem[{~m_bank, c_wa}] = c_wd;
        if (e_rdg) q.push_back('{cyc + 2, m_mem[{m_bank, c_ra}]});
        if (e_dv) void'(q.pop_front());
        m_starve = (!c_wv || e_wrg) ? 0 : (!m_pend && m_starve < LIM) ? m_starve + 1 : m_starve;
        tog    = m_pend ? c_fe : (c_sr && c_fe);
        m_pend = m_pend ? !c_fe : (c_sr && !c_fe);
        m_done = tog;
        m_bank = m_bank ^ tog;
        cyc++;
        @(negedge clk_in);
    endtask

    task automatic apply_reset();
        n_reset_in = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_in);
        n_reset_in = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        rd_valid_in = 1; wr_valid_in = 1; swap_req_in = 1; rd_frame_end_in = 1;
        #1;
        checks++; if ({rd_ready_out, wr_ready_out, ram_en_out, ram_we_out} !== 4'b0) begin
            failures++; $display("FAIL reset_comb: got %b want 0000", {rd_ready_out, wr_ready_out, ram_en_out, ram_we_out}); end
        checks++; if (ram_addr_out !== '0) begin
            failures++; $display("FAIL reset_addr: got %h want 000", ram_addr_out); end
        @(negedge clk_in);
        checks++; if ({front_bank_out, swap_done_out, rd_data_valid_out} !== 3'b0) begin
            failures++; $display("FAIL reset_regs: got %b want 000", {front_bank_out, swap_done_out, rd_data_valid_out}); end
        checks++; if (rd_data_out !== '0) begin
            failures++; $display("FAIL reset_rdata: got %h want 0", rd_data_out); end
        apply_reset();
    endtask

    task automatic test_lone_write();
        drive(0, 0, 1, 11'h005, 24'hFF0000, 0, 0);
        checks++; if (ram_addr_out !== 12'h805 || ram_we_out !== 1'b1 || wr_ready_out !== 1'b1) begin
            failures++; $display("FAIL lone_write: got addr=%h we=%b rdy=%b want 805 1 1", ram_addr_out, ram_we_out, wr_ready_out); end
        checks++; if (ram_wdata_out !== 24'hFF0000) begin
            failures++; $display("FAIL lone_write_data: got %h want ff0000", ram_wdata_out); end
        advance();
        drive(1, 11'h005, 0, 0, 0, 0, 0);
        checks++; if (ram_addr_out !== 12'h005 || ram_we_out !== 1'b0 || rd_ready_out !== 1'b1) begin
            failures++; $display("FAIL lone_read_cmd: got addr=%h we=%b rdy=%b want 005 0 1", ram_addr_out, ram_we_out, rd_ready_out); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (rd_data_valid_out !== 1'b0) begin
            failures++; $display("FAIL lone_read_early: got valid=%b want 0", rd_data_valid_out); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (rd_data_valid_out !== 1'b1 || rd_data_out !== 24'h0) begin
            failures++; $display("FAIL lone_read_data: got valid=%b data=%h want 1 000000", rd_data_valid_out, rd_data_out); end
        advance();
    endtask

    task automatic test_swap_immediate();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, AW'(11'h010 + i), pat[i], 0, 0);
            advance();
        end
        drive(0, 0, 0, 0, 0, 1, 1);
        checks++; if (swap_done_out !== 1'b0 || front_bank_out !== 1'b0) begin
            failures++; $display("FAIL swap_imm_pre: got done=%b bank=%b want 0 0", swap_done_out, front_bank_out); end
        advance();
        drive(0, 0, 1, 11'h020, 24'h777777, 0, 0);
        checks++; if (swap_done_out !== 1'b1 || front_bank_out !== 1'b1) begin
            failures++; $display("FAIL swap_imm_done: got done=%b bank=%b want 1 1", swap_done_out, front_bank_out); end
        checks++; if (wr_ready_out !== 1'b1 || ram_addr_out !== 12'h020) begin
            failures++; $display("FAIL swap_imm_nopend: got rdy=%b addr=%h want 1 020", wr_ready_out, ram_addr_out); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (swap_done_out !== 1'b0 || front_bank_out !== 1'b1) begin
            failures++; $display("FAIL swap_imm_post: got done=%b bank=%b want 0 1", swap_done_out, front_bank_out); end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            drive(k < 4, AW'(11'h010 + k), 0, 0, 0, 0, 0);
            checks++; if (rd_data_valid_out !== (k >= 2 && k <= 5)) begin
                failures++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, rd_data_valid_out, (k >= 2 && k <= 5)); end
            if (k >= 2 && k <= 5) begin
                checks++; if (rd_data_out !== pat[k-2]) begin
                    failures++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rd_data_out, pat[k-2]); end
            end
            advance();
        end
    endtask

    task automatic test_starve();
        drive(0, 0, 0, 0, 0, 0, 0);
        advance();
        for (int i = 1; i <= 20; i++) begin
            drive(1, AW'($urandom), 1, AW'($urandom), PB'($urandom), 0, 0);
            checks++; if (wr_ready_out !== (i == 9 || i == 18) || rd_ready_out !== !(i == 9 || i == 18)) begin
                failures++; $display("FAIL starve[%0d]: got wr=%b rd=%b want %b %b", i, wr_ready_out, rd_ready_out,
                                     (i == 9 || i == 18), !(i == 9 || i == 18)); end
            advance();
        end
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0); advance(); end
    endtask

    task automatic test_swap_pending();
        apply_reset();
        drive(0, 0, 1, 11'h030, 24'h111111, 1, 0);
        checks++; if (wr_ready_out !== 1'b1) begin
            failures++; $display("FAIL pend_req_cycle: got wr=%b want 1", wr_ready_out); end
        advance();
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 1, 11'h031, 24'h222222, 0, i == 10);
            checks++; if (wr_ready_out !== 1'b0 || swap_done_out !== 1'b0 || front_bank_out !== 1'b0) begin
                failures++; $display("FAIL pend_hold[%0d]: got wr=%b done=%b bank=%b want 0 0 0", i, wr_ready_out, swap_done_out, front_bank_out); end
            advance();
        end
        drive(0, 0, 1, 11'h031, 24'h222222, 0, 0);
        checks++; if (swap_done_out !== 1'b1 || front_bank_out !== 1'b1 || wr_ready_out !== 1'b1) begin
            failures++; $display("FAIL pend_done: got done=%b bank=%b wr=%b want 1 1 1", swap_done_out, front_bank_out, wr_ready_out); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (swap_done_out !== 1'b0 || front_bank_out !== 1'b1) begin
            failures++; $display("FAIL pend_pulse: got done=%b bank=%b want 0 1", swap_done_out, front_bank_out); end
        advance();
    endtask

    task automatic test_reset_pending();
        drive(0, 0, 0, 0, 0, 1, 0);
        advance();
        drive(1, 11'h010, 0, 0, 0, 0, 0);
        advance();
        drive(1, 11'h011, 0, 0, 0, 0, 0);
        advance();
        n_reset_in = 1'b0;
        #1;
        checks++; if (rd_data_valid_out !== 1'b0) begin
            failures++; $display("FAIL rstp_async: got valid=%b want 0", rd_data_valid_out); end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, i == 0);
            checks++; if (front_bank_out !== 1'b0 || swap_done_out !== 1'b0 || rd_data_valid_out !== 1'b0) begin
                failures++; $display("FAIL rstp_after[%0d]: got bank=%b done=%b valid=%b want 0 0 0", i, front_bank_out, swap_done_out, rd_data_valid_out); end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7, AW'($urandom), $urandom_range(0, 9) < 6, AW'($urandom),
                  PB'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            checks++; if (rd_ready_out !== e_rdg || wr_ready_out !== e_wrg) begin
                failures++; $display("FAIL rnd_grant[%0d]: got rd=%b wr=%b want %b %b", i, rd_ready_out, wr_ready_out, e_rdg, e_wrg); end
            checks++; if (ram_en_out !== (e_rdg || e_wrg) || ram_we_out !== e_wrg) begin
                failures++; $display("FAIL rnd_cmd[%0d]: got en=%b we=%b want %b %b", i, ram_en_out, ram_we_out, e_rdg || e_wrg, e_wrg); end
            if (e_rdg || e_wrg) begin
                checks++; if (ram_addr_out !== e_addr) begin
                    failures++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, ram_addr_out, e_addr); end
            end
            if (e_wrg) begin
                checks++; if (ram_wdata_out !== c_wd) begin
                    failures++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, ram_wdata_out, c_wd); end
            end
            checks++; if (rd_data_valid_out !== e_dv) begin
                failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, rd_data_valid_out, e_dv); end
            if (e_dv) begin
                checks++; if (rd_data_out !== e_data) begin
                    failures++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rd_data_out, e_data); end
            end
            checks++; if (front_bank_out !== m_bank || swap_done_out !== m_done) begin
                failures++; $display("FAIL rnd_swap[%0d]: got bank=%b done=%b want %b %b", i, front_bank_out, swap_done_out, m_bank, m_done); end
            advance();
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << (AW + 1)); i++) begin
            mem[i] = '0;
            m_mem[i] = '0;
        end
        cyc = 0;
        model_clear();
        @(negedge clk_in);
        test_reset();
        test_lone_write();
        test_swap_immediate();
        test_back_to_back();
        test_starve();
        test_swap_pending();
        test_reset_pending();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
